// File: rtl/insn_fetch_queue_pkg.sv
// Shared widths and defaults for the instruction-fetch prefetch queue.
package insn_fetch_queue_pkg;

  localparam int FETCHQ_DEPTH    = 4;
  localparam int FETCHQ_PC_INC   = 4;
  localparam int FETCHQ_RESET_PC = 0;

  // Pointer width for a DEPTH-entry ring (at least one bit).
  function automatic int fetchq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width able to hold 0..DEPTH.
  function automatic int fetchq_count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/insn_fetch_queue_fetch_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush; DEPTH need not be a power of two.
module fetch_fifo
  import insn_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH,
  parameter int WIDTH = 64,
  localparam int PTR_W = fetchq_ptr_w(DEPTH),
  localparam int CNT_W = fetchq_count_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = ptr_inc(tail_q);
      if (rd_en) head_d = ptr_inc(head_q);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_en) mem_q[tail_q] <= wr_data;
  end

  assign rd_data = mem_q[head_q];
  assign count   = count_q;

endmodule

// File: rtl/insn_fetch_queue.sv
// Instruction-fetch front end: credit-based sequential issue into a prefetch FIFO.
// Optional macro FETCHQ_BYPASS_EN forwards a returning word straight to decode when the FIFO is empty.
module insn_fetch_queue
  import insn_fetch_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = FETCHQ_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] PC_INC   = ADDR_WIDTH'(FETCHQ_PC_INC),
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(FETCHQ_RESET_PC),
  localparam int CNT_W = fetchq_count_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] insnAddr,
  input  logic [INSN_WIDTH-1:0] insn,
  input  logic                  redirectValid,
  input  logic [ADDR_WIDTH-1:0] redirectPc,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [INSN_WIDTH-1:0] outInsn,
  output logic [ADDR_WIDTH-1:0] outPc,
  output logic [CNT_W-1:0]      occupancy
);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;

  logic [CNT_W-1:0]                 fifo_count;
  logic [INSN_WIDTH+ADDR_WIDTH-1:0] fifo_rd_data;
  logic                             fifo_wr, fifo_rd, fifo_nonempty;
  logic                             ret_valid, deq, issue;
  logic [CNT_W:0]                   credit;

  assign fifo_nonempty = (fifo_count != '0);
  assign ret_valid     = inflight_q & ~redirectValid & ~rst;

`ifdef FETCHQ_BYPASS_EN
  logic bypass;
  assign bypass   = ret_valid & ~fifo_nonempty;
  assign outValid = ~rst & (fifo_nonempty | bypass);
  assign outInsn  = bypass ? insn : fifo_rd_data[ADDR_WIDTH +: INSN_WIDTH];
  assign outPc    = bypass ? inflight_pc_q : fifo_rd_data[ADDR_WIDTH-1:0];
  assign fifo_wr  = ret_valid & ~(bypass & outReady);
`else
  assign outValid = ~rst & fifo_nonempty;
  assign outInsn  = fifo_rd_data[ADDR_WIDTH +: INSN_WIDTH];
  assign outPc    = fifo_rd_data[ADDR_WIDTH-1:0];
  assign fifo_wr  = ret_valid;
`endif

  // A redirect cancels the handshake even though outValid still shows old state.
  assign deq     = outValid & outReady & ~redirectValid;
  assign fifo_rd = deq & fifo_nonempty;

  // Entries held plus the one in flight must leave room for the next return.
  assign credit = {1'b0, fifo_count}
                + {{CNT_W{1'b0}}, inflight_q}
                - {{CNT_W{1'b0}}, deq};
  assign issue  = ~rst & (redirectValid | (credit < (CNT_W+1)'(DEPTH)));

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (rst)                insnAddr = RESET_PC;
    else if (redirectValid) insnAddr = redirectPc;
    else                    insnAddr = fetch_pc_q;
    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = insnAddr;
      fetch_pc_d    = insnAddr + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(INSN_WIDTH + ADDR_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirectValid),
    .wr_en  (fifo_wr),
    .wr_data({insn, inflight_pc_q}),
    .rd_en  (fifo_rd),
    .rd_data(fifo_rd_data),
    .count  (fifo_count)
  );

  assign occupancy = rst ? '0 : fifo_count;

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Scoreboard bench for insn_fetch_queue: expected in-order PC stream vs accepted outputs.
module tb_insn_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;
`ifdef FETCHQ_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirectValid = 1'b0;
  logic        outReady = 1'b0;
  logic [31:0] redirectPc = '0;
  logic [31:0] insn = '0;
  logic [31:0] insnAddr, outInsn, outPc;
  logic        outValid;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [31:0] sb[$];

  insn_fetch_queue #(
    .ADDR_WIDTH(32),
    .INSN_WIDTH(32),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .insnAddr     (insnAddr),
    .insn         (insn),
    .redirectValid(redirectValid),
    .redirectPc   (redirectPc),
    .outValid     (outValid),
    .outReady     (outReady),
    .outInsn      (outInsn),
    .outPc        (outPc),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous instruction memory
  always @(posedge clk) insn <= insnAddr ^ MAGIC;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // After a reset or redirect the delivered stream must be start, start+4, ...
  task automatic expect_stream(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 512; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (occupancy > 3'(DEPTH)) begin
        errors++;
        $display("FAIL occ_bound got %0d limit %0d at %0t", occupancy, DEPTH, $time);
      end
    end
    if (!rst && !redirectValid && outValid && outReady) begin
      acc_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got pc %0h expected none at %0t", outPc, $time);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = sb.pop_front();
        if (outPc !== exp_pc || outInsn !== (exp_pc ^ MAGIC)) begin
          errors++;
          $display("FAIL stream got pc %0h insn %0h expected pc %0h insn %0h at %0t",
                   outPc, outInsn, exp_pc, exp_pc ^ MAGIC, $time);
        end
      end
    end
  end

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirectValid = 1'b0;
    outReady = ready;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_outvalid", 32'(outValid), 32'd0);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_addr", insnAddr, 32'd0);
      next_cycle();
    end
    rst = 1'b0;
    expect_stream(32'd0);
  endtask

  task automatic wait_occ(input int target);
    int n;
    n = 0;
    while (occupancy != 3'(target) && n < 20) begin
      next_cycle();
      n++;
    end
    chk("wait_occ", 32'(occupancy), 32'(target));
  endtask

  initial begin
    int first;
    int acc0;
    #1;

    // 1: reset then run, latency and sequence
    do_reset(1'b1);
    first = -1;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (c == 0) chk("first_addr", insnAddr, 32'd0);
      if (outValid && first < 0) first = c;
      next_cycle();
    end
    chk("latency", 32'(first), 32'(EXP_LAT));

    // 2: backpressure fills to DEPTH, then drains one per cycle
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) next_cycle();
    sample();
    chk("bp_occ", 32'(occupancy), 32'(DEPTH));
    chk("bp_addr", insnAddr, 32'd16);
    chk("bp_valid", 32'(outValid), 32'd1);
    next_cycle();
    outReady = 1'b1;
    acc0 = acc_cnt;
    for (int c = 0; c < 10; c++) begin
      sample();
      next_cycle();
    end
    chk("bp_drain_rate", 32'(acc_cnt - acc0), 32'd10);

    // 3: redirect with three entries buffered and one in flight
    do_reset(1'b0);
    wait_occ(3);
    redirectValid = 1'b1;
    redirectPc = 32'h100;
    outReady = 1'b1;
    expect_stream(32'h100);
    sample();
    chk("redir_addr", insnAddr, 32'h100);
    next_cycle();
    redirectValid = 1'b0;
    chk("redir_occ", 32'(occupancy), 32'd0);
    acc0 = acc_cnt;
    for (int c = 0; c < 8; c++) begin
      sample();
      next_cycle();
    end
    chk("redir_progress", 32'(acc_cnt - acc0 >= 5), 32'd1);

    // 4: redirect while full and dequeuing
    do_reset(1'b0);
    wait_occ(DEPTH);
    redirectValid = 1'b1;
    redirectPc = 32'h200;
    outReady = 1'b1;
    expect_stream(32'h200);
    sample();
    chk("redir_full_addr", insnAddr, 32'h200);
    next_cycle();
    redirectValid = 1'b0;
    chk("redir_full_occ", 32'(occupancy), 32'd0);
    for (int c = 0; c < 30; c++) begin
      outReady = ($urandom_range(2) != 0);
      sample();
      next_cycle();
    end

    // 5: reset mid-stream with two entries buffered
    do_reset(1'b0);
    wait_occ(2);
    rst = 1'b1;
    sample();
    chk("mid_rst_valid", 32'(outValid), 32'd0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    next_cycle();
    rst = 1'b0;
    outReady = 1'b1;
    expect_stream(32'd0);
    sample();
    chk("post_rst_valid", 32'(outValid), 32'd0);
    chk("post_rst_occ", 32'(occupancy), 32'd0);
    chk("post_rst_addr", insnAddr, 32'd0);
    next_cycle();
    for (int c = 0; c < 6; c++) begin
      sample();
      next_cycle();
    end

    // 6: random backpressure and redirects
    for (int c = 0; c < 300; c++) begin
      outReady = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) begin
        redirectValid = 1'b1;
        redirectPc = $urandom & 32'hFFFF_FFFC;
        expect_stream(redirectPc);
        sample();
        chk("rand_redir_addr", insnAddr, redirectPc);
      end else begin
        redirectValid = 1'b0;
        sample();
      end
      next_cycle();
    end
    redirectValid = 1'b0;

    chk("accepted_total", 32'(acc_cnt > 150), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
